sensor_adc_sequencer: RTL

- Sequences the radiation sensor and ADC for one measurement request from the adapter.
- Powers up the sensor, waits for it to settle, then powers up the ADC and waits again.
- Performs 1/2/4/8 read handshakes, averages the samples, then powers both down.
- Sits between the adapter (command side) and the sens_*/adc_* pins. Its adc_conversion_complete input is already synchronised.

---
 rtl/sensor_adc_seq_pkg.sv | 26 ++
 rtl/sensor_adc_sequencer_cnt.sv | 36 +++
 rtl/sensor_adc_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_adc_seq_pkg.sv
// Shared types and sizing helpers for the sensor/ADC sequencer.
// Holds the FSM state type, datapath widths and counter-width function.
package sensor_adc_seq_pkg;

  localparam int SAMPLE_CNT_W = 4;
  localparam int ACC_W        = 19;

  typedef enum logic [2:0] {
    IDLE,
    SENS_SETTLE,
    ADC_SETTLE,
    READ,
    RELEASE,
    FINISH
  } state_t;

  // Bits needed to hold (max tick count - 1).
  function automatic int cnt_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sensor_adc_sequencer_cnt.sv
// Loadable down counter shared by settle and timeout phases.
// Ports: load/load_value, dec (decrement enable), zero flag.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sensor_adc_sequencer.sv
// Sequences sensor power-up, ADC settle, N read handshakes and averaging.
// Ports: start/abort/cfg/avg_log2 in; busy/done/result/timed_out; sens_*/adc_* pins.
module sensor_adc_sequencer
  import sensor_adc_seq_pkg::*;
#(
  parameter int SENS_SETTLE_TICKS = 64,
  parameter int ADC_SETTLE_TICKS  = 16,
  parameter int TIMEOUT_TICKS     = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  cfg,
  input  logic [1:0]  avg_log2,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        timed_out,
  output logic [2:0]  sens_config,
  output logic        sens_enable,
  output logic        sens_read,
  output logic        adc_enable,
  output logic        adc_read,
  input  logic        adc_conversion_complete,
  input  logic [15:0] adc_value
);

  localparam int CNT_W = cnt_width(SENS_SETTLE_TICKS,
                                   ADC_SETTLE_TICKS,
                                   TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] SENS_LD = CNT_W'(SENS_SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] ADC_LD  = CNT_W'(ADC_SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT_TICKS - 1);

  state_t                  state_q, state_d;
  logic [2:0]              cfg_q, cfg_d;
  logic [1:0]              avg_q, avg_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [15:0]             result_q, result_d;
  logic                    timed_q, timed_d;
  logic                    sens_en_q, sens_en_d;
  logic                    adc_en_q, adc_en_d;
  logic                    rd_q, rd_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [SAMPLE_CNT_W-1:0] smp_q, smp_d;

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             dec;
  logic             cnt_zero;
  logic             fin;
  logic             fin_to;
  logic             cc;

  assign cc = adc_conversion_complete;

  seq_down_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .load_value(ld_val),
    .dec       (dec),
    .zero      (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    avg_d     = avg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    timed_d   = timed_q;
    sens_en_d = sens_en_q;
    adc_en_d  = adc_en_q;
    rd_d      = rd_q;
    acc_d     = acc_q;
    smp_d     = smp_q;
    ld        = 1'b0;
    ld_val    = '0;
    dec       = 1'b0;
    fin       = 1'b0;
    fin_to    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cfg_d     = cfg;
          avg_d     = avg_log2;
          sens_en_d = 1'b1;
          busy_d    = 1'b1;
          ld        = 1'b1;
          ld_val    = SENS_LD;
          state_d   = SENS_SETTLE;
        end
      end
      SENS_SETTLE: begin
        if (cnt_zero) begin
          adc_en_d = 1'b1;
          ld       = 1'b1;
          ld_val   = ADC_LD;
          state_d  = ADC_SETTLE;
        end else begin
          dec = 1'b1;
        end
      end
      ADC_SETTLE: begin
        // A stale complete from a prior conversion must clear first.
        if (!cnt_zero) begin
          dec = 1'b1;
        end else if (!cc) begin
          rd_d    = 1'b1;
          ld      = 1'b1;
          ld_val  = TO_LD;
          state_d = READ;
        end
      end
      READ: begin
        if (cc) begin
          acc_d   = acc_q + ACC_W'(adc_value);
          rd_d    = 1'b0;
          smp_d   = smp_q + SAMPLE_CNT_W'(1);
          ld      = 1'b1;
          ld_val  = TO_LD;
          state_d = RELEASE;
        end else if (cnt_zero) begin
          fin    = 1'b1;
          fin_to = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      RELEASE: begin
        if (!cc) begin
          if (smp_q == (SAMPLE_CNT_W'(1) << avg_q)) begin
            fin = 1'b1;
          end else begin
            rd_d    = 1'b1;
            ld      = 1'b1;
            ld_val  = TO_LD;
            state_d = READ;
          end
        end else if (cnt_zero) begin
          fin    = 1'b1;
          fin_to = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      FINISH: begin
        acc_d   = '0;
        smp_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so FINISH's pulse is set on entry:
    // done is high and busy already low during the FINISH cycle.
    if (fin) begin
      state_d   = FINISH;
      sens_en_d = 1'b0;
      adc_en_d  = 1'b0;
      rd_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      timed_d   = fin_to;
      result_d  = 16'(acc_q >> avg_q);
    end

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      sens_en_d = 1'b0;
      adc_en_d  = 1'b0;
      rd_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      result_d  = result_q;
      timed_d   = timed_q;
      acc_d     = '0;
      smp_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      avg_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      timed_q   <= 1'b0;
      sens_en_q <= 1'b0;
      adc_en_q  <= 1'b0;
      rd_q      <= 1'b0;
      acc_q     <= '0;
      smp_q     <= '0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      avg_q     <= avg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      timed_q   <= timed_d;
      sens_en_q <= sens_en_d;
      adc_en_q  <= adc_en_d;
      rd_q      <= rd_d;
      acc_q     <= acc_d;
      smp_q     <= smp_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign timed_out   = timed_q;
  assign sens_config = cfg_q;
  assign sens_enable = sens_en_q;
  assign sens_read   = rd_q;
  assign adc_enable  = adc_en_q;
  assign adc_read    = rd_q;

endmodule
